mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter and controller for a shared 2:1 mux channel.
- Two requesters (A, B) each drive valid/ready/data. The block decides which one owns the single output channel and drives the mux select. It also routes data, valid and ready between the owner and the channel.
- A burst limit prevents one requester from starving the other.
- Sits between two producers and one downstream consumer.

Parameters:
- DATA_W, 8, width of each data path and of out_data.
- MAX_BURST, 4, maximum consecutive accepted beats for one owner while the other requester is waiting. Legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A has a beat.
- a_data  input  DATA_W  requester A data.
- a_ready  output  1  beat from A accepted this cycle.
- b_valid  input  1  requester B has a beat.
- b_data  input  DATA_W  requester B data.
- b_ready  output  1  beat from B accepted this cycle.
- out_valid  output  1  shared channel valid.
- out_data  output  DATA_W  shared channel data (mux output).
- out_ready  input  1  downstream accepts.
- sel  output  1  registered mux select, 0=A, 1=B.
- busy  output  1  high in GRANT_A or GRANT_B.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sel=0, last=1 (so A wins the first tie), beat_cnt=0.
  - a_ready=0, b_ready=0, out_valid=0, busy=0, out_data=0.
- States: IDLE, GRANT_A, GRANT_B.
- Channel routing:
  - GRANT_A: out_valid=a_valid, out_data=a_data, a_ready=out_ready, b_ready=0.
  - GRANT_B: mirror of GRANT_A.
  - IDLE: out_valid=0, both readys=0, out_data=0.
- Transfer: a beat transfers when the owner's valid=1 and out_ready=1 in the same cycle.
- IDLE transitions:
  - Only one valid high: grant that requester.
  - Both high: grant the requester that is not `last`.
  - Neither high: stay in IDLE.
  - Grant takes effect on the next cycle (1-cycle arbitration latency). sel and last update with the state.
- Switching rules while granted (owner X, other Y):
  - Owner valid=0: go to GRANT_Y if Y valid, else IDLE. beat_cnt=0.
  - Transfer with beat_cnt==MAX_BURST-1 and Y valid: go to GRANT_Y, beat_cnt=0.
  - Transfer with beat_cnt==MAX_BURST-1 and Y not valid: stay, beat_cnt=0.
  - Other transfers: beat_cnt+1.
  - Stall (owner valid=1, out_ready=0): hold state and beat_cnt. Never switch while an owner beat is pending.
- Requester rule: valid, once asserted, is held with stable data until ready. The arbiter relies on this and does not check it.
- Handover latency: the new owner's first beat can transfer in the cycle after the switch. No bubble beyond that one cycle.
- MAX_BURST=1: strict alternation whenever both requesters are valid.
- beat_cnt width: $clog2(MAX_BURST+1), minimum 1 bit.
- Reset asserted mid-burst: immediate return to reset values. Any in-flight beat is not accepted.
- out_ready=1 with no owner: no effect.

Optional Feature:
- Macro: MUX2_ARB_STATS_EN.
- Defined:
  - Adds output ports grant_cnt_a and grant_cnt_b (16 bits each).
  - Each counts accepted beats from its requester, saturating at 16'hFFFF.
  - Both reset to 0 by rst_n.
  - Adds input stats_clr (1 bit); a high cycle clears both counters synchronously. If a transfer happens in the same cycle, clear wins.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package mux2_arb_pkg holds:
  - State encoding (IDLE=2'd0, GRANT_A=2'd1, GRANT_B=2'd2).
  - Select constants SEL_A=1'b0, SEL_B=1'b1.
- Natural sub-module: mux2_arb_burst_cnt. It implements the beat counter with inc/clr/limit-hit outputs, and is reused by the stats counters in saturating mode.

Test Plan:
- Reset with both valids high, release rst_n: cycle 1 grants A (sel=0). A streams 0x11,0x22 with out_ready=1, and out_data follows.
- MAX_BURST=4, both valid continuously, out_ready=1: beat pattern is A,A,A,A, one handover cycle, then B,B,B,B, then A. sel toggles after every 4th beat.
- A valid with out_ready=0 for 5 cycles while B is valid: sel stays 0, no switch, a_ready=0. Then out_ready=1: A beat accepted, arbitration continues.
- A drops valid after 2 beats with B idle: IDLE next cycle, out_valid=0, busy=0. B then raises valid: GRANT_B on the following cycle, sel=1.
- Assert rst_n=0 asynchronously mid-burst (beat_cnt=2): all outputs return to reset values immediately. After release, A wins the tie.
- With MUX2_ARB_STATS_EN defined, after 7 A beats and 3 B beats: grant_cnt_a=7, grant_cnt_b=3. stats_clr pulsed in the same cycle as a transfer gives 0 for both.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int unsigned STATS_W = 16;

    // Counter width able to hold 0..max_burst, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        int unsigned w;
        w = $clog2(max_burst + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux2_arb_burst_cnt.sv
// Beat counter with increment/clear; wraps to zero at LIMIT-1, or holds there when SATURATE is set.
module mux2_arb_burst_cnt #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned LIMIT    = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_limit_hit_c
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;

    assign o_cnt         = r_cnt;
    assign o_limit_hit_c = (r_cnt == LAST);

    // Clear has priority over increment.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc) begin
            if (o_limit_hit_c) begin
                w_cnt_nxt = SATURATE ? r_cnt : '0;
            end else begin
                w_cnt_nxt = r_cnt + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner arbitration and channel routing for a shared 2:1 mux with burst limiting.
// Define MUX2_ARB_STATS_EN to add per-requester accepted-beat counters.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
`ifdef MUX2_ARB_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [STATS_W-1:0] grant_cnt_a,
    output logic [STATS_W-1:0] grant_cnt_b
`endif
);

    localparam int unsigned CNT_W = cnt_width(MAX_BURST);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_sel;
    logic             w_sel_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_busy;
    logic             w_cnt_clr;
    logic             w_at_limit;
    logic             w_xfer_a;
    logic             w_xfer_b;
    logic             w_xfer;
    logic [CNT_W-1:0] w_beat_cnt;

    assign sel  = r_sel;
    assign busy = r_busy;

    assign w_xfer_a = (r_state == GRANT_A) && a_valid && out_ready;
    assign w_xfer_b = (r_state == GRANT_B) && b_valid && out_ready;
    assign w_xfer   = w_xfer_a || w_xfer_b;

    // Owner routing is combinational from the registered state so a new owner can move a beat right after handover.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        case (r_state)
            GRANT_A: begin
                out_valid = a_valid;
                out_data  = a_data;
                a_ready   = out_ready;
            end
            GRANT_B: begin
                out_valid = b_valid;
                out_data  = b_data;
                b_ready   = out_ready;
            end
            default: ;
        endcase
    end

    // The counter wraps to zero on the limit beat, which covers both the hand-over and stay cases.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (a_valid && (!b_valid || (r_last == SEL_B))) begin
                    w_state_nxt = GRANT_A;
                    w_sel_nxt   = SEL_A;
                    w_last_nxt  = SEL_A;
                end else if (b_valid) begin
                    w_state_nxt = GRANT_B;
                    w_sel_nxt   = SEL_B;
                    w_last_nxt  = SEL_B;
                end
            end
            GRANT_A: begin
                if (!a_valid) begin
                    w_cnt_clr = 1'b1;
                    if (b_valid) begin
                        w_state_nxt = GRANT_B;
                        w_sel_nxt   = SEL_B;
                        w_last_nxt  = SEL_B;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (out_ready && w_at_limit && b_valid) begin
                    w_state_nxt = GRANT_B;
                    w_sel_nxt   = SEL_B;
                    w_last_nxt  = SEL_B;
                end
            end
            GRANT_B: begin
                if (!b_valid) begin
                    w_cnt_clr = 1'b1;
                    if (a_valid) begin
                        w_state_nxt = GRANT_A;
                        w_sel_nxt   = SEL_A;
                        w_last_nxt  = SEL_A;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (out_ready && w_at_limit && a_valid) begin
                    w_state_nxt = GRANT_A;
                    w_sel_nxt   = SEL_A;
                    w_last_nxt  = SEL_A;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    // Reset leaves last pointing at B so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= SEL_A;
            r_last  <= SEL_B;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    mux2_arb_burst_cnt #(
        .WIDTH    (CNT_W),
        .LIMIT    (MAX_BURST),
        .SATURATE (1'b0)
    ) u_beat_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_inc         (w_xfer),
        .i_clr         (w_cnt_clr),
        .o_cnt         (w_beat_cnt),
        .o_limit_hit_c (w_at_limit)
    );

    a_beat_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        w_beat_cnt < CNT_W'(MAX_BURST));

`ifdef MUX2_ARB_STATS_EN
    logic w_stats_sat_a;
    logic w_stats_sat_b;

    // Accepted-beat statistics; a clear in the same cycle as a transfer wins.
    mux2_arb_burst_cnt #(
        .WIDTH    (STATS_W),
        .LIMIT    (1 << STATS_W),
        .SATURATE (1'b1)
    ) u_stats_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_inc         (w_xfer_a),
        .i_clr         (stats_clr),
        .o_cnt         (grant_cnt_a),
        .o_limit_hit_c (w_stats_sat_a)
    );

    mux2_arb_burst_cnt #(
        .WIDTH    (STATS_W),
        .LIMIT    (1 << STATS_W),
        .SATURATE (1'b1)
    ) u_stats_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_inc         (w_xfer_b),
        .i_clr         (stats_clr),
        .o_cnt         (grant_cnt_b),
        .o_limit_hit_c (w_stats_sat_b)
    );
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: requester queues drive stimulus, a scoreboard checks every accepted beat.
// Stats counter checks are compiled in when MUX2_ARB_STATS_EN is defined.
module tb_mux2_rr_arbiter;

    typedef struct packed {
        logic       sel;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0;
    logic [7:0] a_data = '0;
    logic       a_ready;
    logic       b_valid = 1'b0;
    logic [7:0] b_data = '0;
    logic       b_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       sel;
    logic       busy;
`ifdef MUX2_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] grant_cnt_a;
    logic [15:0] grant_cnt_b;
`endif

    logic [7:0] src_a[$];
    logic [7:0] src_b[$];
    exp_t       exp_q[$];
    logic       a_acc_q = 1'b0;
    logic       b_acc_q = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;

    mux2_rr_arbiter #(
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
`ifdef MUX2_ARB_STATS_EN
        .stats_clr   (stats_clr),
        .grant_cnt_a (grant_cnt_a),
        .grant_cnt_b (grant_cnt_b),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_beat(input logic s, input logic [7:0] d);
        exp_t e;
        e.sel  = s;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        a_valid = (src_a.size() != 0);
        a_data  = (src_a.size() != 0) ? src_a[0] : 8'h00;
        b_valid = (src_b.size() != 0);
        b_data  = (src_b.size() != 0) ? src_b[0] : 8'h00;
    endtask

    // One clock: retire beats accepted on the edge, then present the next ones.
    task automatic step();
        @(posedge clk);
        #1;
        if (a_acc_q && src_a.size() != 0) void'(src_a.pop_front());
        if (b_acc_q && src_b.size() != 0) void'(src_b.pop_front());
        drive();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || src_a.size() != 0 || src_b.size() != 0) && n < 100) begin
            step();
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
        chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    always @(negedge clk) begin
        a_acc_q = a_valid && a_ready;
        b_acc_q = b_valid && b_ready;
    end

    // Scoreboard monitor: every beat the channel accepts must match the next expected beat.
    always @(negedge clk) begin
        exp_t e;
        logic owner_rdy;
        if (rst_n && out_valid && out_ready) begin
            owner_rdy = sel ? b_ready : a_ready;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL beat_unexpected: got sel=%0d data=0x%0h with no beat expected", sel, out_data);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {22'd0, sel, owner_rdy, out_data}, {22'd0, e.sel, 1'b1, e.data});
            end
        end
    end

    initial begin
        // Reset with both requesters valid.
        out_ready = 1'b1;
        src_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        src_b = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);

        expect_beat(1'b0, 8'h11); expect_beat(1'b0, 8'h22);
        expect_beat(1'b0, 8'h33); expect_beat(1'b0, 8'h44);
        expect_beat(1'b1, 8'hB1); expect_beat(1'b1, 8'hB2);
        expect_beat(1'b1, 8'hB3); expect_beat(1'b1, 8'hB4);
        expect_beat(1'b0, 8'h55);
        rst_n = 1'b1;
        step();
        chk("first_grant", {30'd0, busy, sel}, {30'd0, 1'b1, 1'b0});
        wait_idle("burst_idle");

        // Stall: A owns the channel while B waits; nothing may switch.
        out_ready = 1'b0;
        src_a.push_back(8'hA1);
        drive();
        step();
        src_b.push_back(8'hB5);
        drive();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold", {29'd0, sel, a_ready, b_ready}, 32'd0);
            chk("stall_busy", {30'd0, busy, out_valid}, {30'd0, 1'b1, 1'b1});
        end
        expect_beat(1'b0, 8'hA1);
        expect_beat(1'b1, 8'hB5);
        out_ready = 1'b1;
        wait_idle("stall_idle");

        // A drops after two beats with B idle, then B requests alone.
        expect_beat(1'b0, 8'hC1); expect_beat(1'b0, 8'hC2);
        src_a = '{8'hC1, 8'hC2};
        drive();
        repeat (4) step();
        chk("drop_idle", {30'd0, busy, out_valid}, 32'd0);
        expect_beat(1'b1, 8'hD1);
        src_b.push_back(8'hD1);
        drive();
        step();
        chk("b_grant", {30'd0, busy, sel}, {30'd0, 1'b1, 1'b1});
        wait_idle("b_idle");

        // Asynchronous reset while A is mid-burst with two beats accepted.
        expect_beat(1'b0, 8'hE1); expect_beat(1'b0, 8'hE2);
        src_a = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        drive();
        repeat (3) step();
        src_b.push_back(8'hF1);
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {28'd0, sel, busy, a_ready, b_ready}, 32'd0);
        chk("async_rst_out", {23'd0, out_valid, out_data}, 32'd0);
        expect_beat(1'b0, 8'hE3); expect_beat(1'b0, 8'hE4);
        expect_beat(1'b1, 8'hF1);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_grant", {30'd0, busy, sel}, {30'd0, 1'b1, 1'b0});
        wait_idle("post_rst_idle");

`ifdef MUX2_ARB_STATS_EN
        // Stats: seven A beats, three B beats, then a clear coinciding with a transfer.
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        for (int i = 0; i < 4; i++) expect_beat(1'b0, 8'h60 + 8'(i));
        for (int i = 0; i < 3; i++) expect_beat(1'b1, 8'h70 + 8'(i));
        for (int i = 4; i < 7; i++) expect_beat(1'b0, 8'h60 + 8'(i));
        for (int i = 0; i < 7; i++) src_a.push_back(8'h60 + 8'(i));
        for (int i = 0; i < 3; i++) src_b.push_back(8'h70 + 8'(i));
        drive();
        wait_idle("stats_idle");
        chk("grant_cnt_a", {16'd0, grant_cnt_a}, 32'd7);
        chk("grant_cnt_b", {16'd0, grant_cnt_b}, 32'd3);
        expect_beat(1'b0, 8'h9A);
        src_a.push_back(8'h9A);
        drive();
        step();
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("stats_clr_wins", {grant_cnt_b, grant_cnt_a}, 32'd0);
        wait_idle("stats_clr_idle");
`endif

        repeat (2) step();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
